sprite_rom_arbiter: RTL and testbench

//  Shares the single sprite ROM (60x60 pieces + digits 0-9, 3600 words each,

---
 rtl/sprite_rom_arbiter_if.sv | 42 ++++
 rtl/sprite_rom_arbiter.sv | 125 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus: two pixel requesters plus the ROM read port.
// master = requesters and ROM; slave = the arbiter.
interface sprite_rom_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 24
);
  logic              a_req;
  logic [3:0]        a_code;
  logic [5:0]        a_row;
  logic [5:0]        a_col;
  logic              a_gnt;
  logic              a_valid;
  logic [PIX_W-1:0]  a_data;
  logic              b_req;
  logic [3:0]        b_digit;
  logic [5:0]        b_row;
  logic [5:0]        b_col;
  logic              b_gnt;
  logic              b_valid;
  logic [PIX_W-1:0]  b_data;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_q;

  modport master (
    output a_req, a_code, a_row, a_col,
    input  a_gnt, a_valid, a_data,
    output b_req, b_digit, b_row, b_col,
    input  b_gnt, b_valid, b_data,
    input  rom_rd, rom_addr,
    output rom_q
  );

  modport slave (
    input  a_req, a_code, a_row, a_col,
    output a_gnt, a_valid, a_data,
    input  b_req, b_digit, b_row, b_col,
    output b_gnt, b_valid, b_data,
    output rom_rd, rom_addr,
    input  rom_q
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares the sprite ROM between piece (A) and digit (B) renderers.
// Macro SPRITE_ARB_FIXED_PRIO_EN: A always wins ties (default round-robin).
module sprite_rom_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int PIX_W      = 24,
  parameter int ROM_LAT    = 2,
  parameter int SPRITE_DIM = 60
) (
  input logic Clk,
  input logic Reset_n,
  sprite_rom_arbiter_if.slave bus
);

  localparam int WORDS = SPRITE_DIM * SPRITE_DIM;
  localparam logic [ADDR_W-1:0] WORDS_W = ADDR_W'(WORDS);
  localparam logic [ADDR_W-1:0] DIG_BASE = ADDR_W'(12 * WORDS);
  localparam logic [5:0] DIM6 = 6'(SPRITE_DIM);

  typedef struct packed {
    logic v;
    logic port;
    logic t;
  } tag_t;

  tag_t pipe [ROM_LAT+1];
  tag_t head;

  logic              pick_b;
  logic              gnt_any;
  logic [3:0]        a_slot;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              a_t;
  logic              b_t;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_t;

  function automatic logic [ADDR_W-1:0] row_off(
    input logic [5:0] r
  );
    logic [ADDR_W-1:0] w;
    w = ADDR_W'(r);
    return (w << 6) - (w << 2);
  endfunction

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  // Tie goes to A unconditionally
  always_comb begin
    pick_b = bus.b_req & ~bus.a_req;
  end
`else
  logic last_b;

  // Tie goes to the port not granted last
  always_comb begin
    pick_b = bus.b_req & (~bus.a_req | ~last_b);
  end

  // Round-robin pointer: remembers the last granted port
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) last_b <= 1'b1;
    else if (gnt_any) last_b <= pick_b;
  end
`endif

  // Grants, address generation and transparency detection
  always_comb begin
    bus.a_gnt = Reset_n & bus.a_req & ~pick_b;
    bus.b_gnt = Reset_n & pick_b;
    gnt_any   = bus.a_gnt | bus.b_gnt;
    a_slot    = {bus.a_code[2:0] - 3'd1, ~bus.a_code[3]};
    a_addr    = ADDR_W'(a_slot) * WORDS_W
              + row_off(bus.a_row)
              + ADDR_W'(bus.a_col);
    b_addr    = DIG_BASE
              + ADDR_W'(bus.b_digit) * WORDS_W
              + row_off(bus.b_row)
              + ADDR_W'(bus.b_col);
    a_t = (bus.a_code[2:0] == 3'd0)
        | (bus.a_code[2:0] == 3'd7)
        | (bus.a_row >= DIM6)
        | (bus.a_col >= DIM6);
    b_t = (bus.b_digit > 4'd9)
        | (bus.b_row >= DIM6)
        | (bus.b_col >= DIM6);
    sel_addr = pick_b ? b_addr : a_addr;
    sel_t    = pick_b ? b_t : a_t;
  end

  // ROM strobe and address; address holds when no real read
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.rom_rd   <= 1'b0;
      bus.rom_addr <= '0;
    end else begin
      bus.rom_rd <= gnt_any & ~sel_t;
      if (gnt_any & ~sel_t) bus.rom_addr <= sel_addr;
    end
  end

  // Tag pipeline tracking each grant through the ROM latency
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k <= ROM_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{v: gnt_any, port: pick_b, t: sel_t};
      for (int k = 1; k <= ROM_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Return path: steer rom_q to the tagged port, zero if transparent
  always_comb begin
    head        = pipe[ROM_LAT];
    bus.a_valid = head.v & ~head.port;
    bus.b_valid = head.v & head.port;
    bus.a_data  = '0;
    bus.b_data  = '0;
    unique case (1'b1)
      bus.a_valid & ~head.t: bus.a_data = bus.rom_q;
      bus.b_valid & ~head.t: bus.b_data = bus.rom_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter.
// Directed vectors; a monitor checks ROM strobes and returns.
module tb_sprite_rom_arbiter;

  localparam int LAT = 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int          cyc;
    logic        rd;
    logic [16:0] addr;
  } rexp_t;

  typedef struct {
    int          cyc;
    logic [23:0] d;
  } dexp_t;

  rexp_t rq[$];
  dexp_t aq[$];
  dexp_t bq[$];
  rexp_t rh;
  dexp_t dh;

  logic        rv [LAT];
  logic [16:0] ra [LAT];

  int   ai;
  int   bi;
  logic turn_b;

  sprite_rom_arbiter_if #(.ADDR_W(17), .PIX_W(24)) bus ();

  sprite_rom_arbiter #(
    .ADDR_W(17), .PIX_W(24), .ROM_LAT(LAT), .SPRITE_DIM(60)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [23:0] romval(input logic [16:0] a);
    return {7'h2B, a} ^ 24'h5A5A5A;
  endfunction

  // ROM model with LAT cycles of read latency; garbage when idle
  always @(posedge Clk) begin
    rv[0] <= bus.rom_rd;
    ra[0] <= bus.rom_addr;
    for (int k = 1; k < LAT; k++) begin
      rv[k] <= rv[k-1];
      ra[k] <= ra[k-1];
    end
  end

  assign bus.rom_q = rv[LAT-1] ? romval(ra[LAT-1]) : 24'hBADBAD;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic port, input int adr);
    rexp_t r;
    dexp_t d;
    r.cyc  = cyc + 1;
    r.rd   = (adr >= 0);
    r.addr = (adr >= 0) ? 17'(adr) : 17'd0;
    d.cyc  = cyc + 1 + LAT;
    d.d    = (adr >= 0) ? romval(17'(adr)) : 24'd0;
    rq.push_back(r);
    if (port) bq.push_back(d);
    else aq.push_back(d);
  endtask

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1
  task automatic vec(
    input logic ar, input logic [3:0] ac,
    input logic [5:0] arow, input logic [5:0] acol,
    input logic br, input logic [3:0] bd,
    input logic [5:0] brow, input logic [5:0] bcol,
    input logic eag, input logic ebg,
    input int aadr, input int badr
  );
    bus.a_req   = ar;
    bus.a_code  = ac;
    bus.a_row   = arow;
    bus.a_col   = acol;
    bus.b_req   = br;
    bus.b_digit = bd;
    bus.b_row   = brow;
    bus.b_col   = bcol;
    @(negedge Clk);
    chk("a_gnt", 32'(bus.a_gnt), 32'(eag));
    chk("b_gnt", 32'(bus.b_gnt), 32'(ebg));
    if (bus.a_gnt && eag) push(1'b0, aadr);
    if (bus.b_gnt && ebg) push(1'b1, badr);
    @(posedge Clk);
    #1;
  endtask

  task automatic a_only(input logic [3:0] c, input logic [5:0] r,
                        input logic [5:0] k, input int adr);
    vec(1, c, r, k, 0, 0, 0, 0, 1, 0, adr, -1);
  endtask

  task automatic b_only(input logic [3:0] d, input logic [5:0] r,
                        input logic [5:0] k, input int adr);
    vec(0, 0, 0, 0, 1, d, r, k, 0, 1, -1, adr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_gnt"}, 32'(bus.a_gnt), 0);
    chk({tag, "_b_gnt"}, 32'(bus.b_gnt), 0);
    chk({tag, "_a_valid"}, 32'(bus.a_valid), 0);
    chk({tag, "_b_valid"}, 32'(bus.b_valid), 0);
    chk({tag, "_a_data"}, 32'(bus.a_data), 0);
    chk({tag, "_b_data"}, 32'(bus.b_data), 0);
    chk({tag, "_rom_rd"}, 32'(bus.rom_rd), 0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
  endtask

  // Monitor: ROM strobe slots and per-port returns against the queues
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        rh = rq.pop_front();
        chk("rom_rd", 32'(bus.rom_rd), 32'(rh.rd));
        if (rh.rd) chk("rom_addr", 32'(bus.rom_addr), 32'(rh.addr));
      end else if (bus.rom_rd) begin
        chk("rom_rd_unexpected", 32'(bus.rom_rd), 0);
      end
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        rh = rq.pop_front();
        chk("rom_slot_missed", 32'(rh.cyc), 32'(cyc));
      end
      if (bus.a_valid) begin
        if (aq.size() == 0) begin
          chk("a_valid_stale", 32'(bus.a_valid), 0);
        end else begin
          dh = aq.pop_front();
          chk("a_latency", 32'(cyc), 32'(dh.cyc));
          chk("a_data", 32'(bus.a_data), 32'(dh.d));
        end
      end else if (aq.size() > 0 && aq[0].cyc <= cyc) begin
        dh = aq.pop_front();
        chk("a_valid_missing", 32'(bus.a_valid), 1);
      end
      if (bus.b_valid) begin
        if (bq.size() == 0) begin
          chk("b_valid_stale", 32'(bus.b_valid), 0);
        end else begin
          dh = bq.pop_front();
          chk("b_latency", 32'(cyc), 32'(dh.cyc));
          chk("b_data", 32'(bus.b_data), 32'(dh.d));
        end
      end else if (bq.size() > 0 && bq[0].cyc <= cyc) begin
        dh = bq.pop_front();
        chk("b_valid_missing", 32'(bus.b_valid), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.a_req   = 0;
    bus.a_code  = 0;
    bus.a_row   = 0;
    bus.a_col   = 0;
    bus.b_req   = 0;
    bus.b_digit = 0;
    bus.b_row   = 0;
    bus.b_col   = 0;
    @(negedge Clk);
    chk_zero("reset");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle(2);

    // Single A read: white pawn origin
    a_only(4'b0001, 0, 0, 3600);
    idle(4);

    // Corner and row-offset addresses, back to back
    a_only(4'b1110, 6'd59, 6'd59, 39599);
    a_only(4'b0101, 6'd1, 6'd0, 32460);
    idle(3);

    // Digit path and an out-of-range digit
    b_only(4'd9, 6'd1, 6'd2, 75662);
    b_only(4'd12, 0, 0, -1);
    b_only(4'd9, 6'd59, 6'd59, 79199);
    idle(4);

    // Both ports held: alternate (or A only under fixed priority)
    ai = 0;
    bi = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      turn_b = 1'b0;
`else
      turn_b = i[0];
`endif
      vec(1, 4'b0010, 6'(ai), 0, 1, 4'(bi), 0, 6'(bi),
          !turn_b, turn_b, 10800 + 60 * ai, 43200 + 3600 * bi + bi);
      if (turn_b) bi++;
      else ai++;
    end
    idle(4);

    // Transparent requests interleaved with real reads
    a_only(4'b0000, 0, 0, -1);
    a_only(4'b0001, 0, 1, 3601);
    a_only(4'b0001, 6'd60, 0, -1);
    b_only(4'd0, 0, 0, 43200);
    a_only(4'b0111, 0, 0, -1);
    b_only(4'd3, 6'd60, 0, -1);
    a_only(4'b0001, 0, 6'd60, -1);
    b_only(4'd1, 6'd59, 6'd59, 50399);
    idle(4);

    // Reset with two reads in flight
    a_only(4'b0001, 6'd2, 6'd3, 3723);
    a_only(4'b1001, 0, 0, 0);
    Reset_n = 1'b0;
    rq.delete();
    aq.delete();
    bq.delete();
    @(negedge Clk);
    chk_zero("midreset");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle(5);
    a_only(4'b0011, 0, 0, 18000);
    idle(2);

    for (int i = 0; i < 20; i++) begin
      if (rq.size() + aq.size() + bq.size() == 0) break;
      @(posedge Clk);
    end
    #1;
    chk("drain", 32'(rq.size() + aq.size() + bq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
